// File: rtl/gpio_seq_pkg.sv
// Shared types for the GPIO pattern sequencer: FSM state encoding and the
// GPIO peripheral byte-register map.
package gpio_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DIR_HI,
    DIR_LO,
    WR_HI,
    WR_LO,
    RD_HI,
    RD_LO,
    WAIT,
    STEP
  } seq_state_e;

  localparam logic [1:0] GPIO_OUT_HI = 2'b00;
  localparam logic [1:0] GPIO_OUT_LO = 2'b01;
  localparam logic [1:0] GPIO_DIR_HI = 2'b10;
  localparam logic [1:0] GPIO_DIR_LO = 2'b11;

endpackage

// File: rtl/gpio_seq_if.sv
// 2-bit-addressed byte register bus; master drives the request and
// receives read data, slave the reverse.
interface gpio_seq_if;
  logic [1:0] ad;
  logic [7:0] di;
  logic       rw;
  logic       cs;
  logic [7:0] dout;

  modport master (output ad, di, rw, cs, input dout);
  modport slave  (input ad, di, rw, cs, output dout);
endinterface

// File: rtl/gpio_port_arb.sv
// CPU/sequencer mux for the GPIO register port. The CPU always wins and its
// select doubles as the sequencer stall.
module gpio_port_arb (
  gpio_seq_if.slave  cpu,
  gpio_seq_if.master gpio,
  input  logic [1:0] seq_ad_i,
  input  logic [7:0] seq_di_i,
  input  logic       seq_rw_i,
  input  logic       seq_cs_i,
  output logic       stall_o
);

  assign stall_o  = cpu.cs;
  assign gpio.ad  = cpu.cs ? cpu.ad : seq_ad_i;
  assign gpio.di  = cpu.cs ? cpu.di : seq_di_i;
  assign gpio.rw  = cpu.cs ? cpu.rw : seq_rw_i;
  assign gpio.cs  = cpu.cs | seq_cs_i;
  assign cpu.dout = gpio.dout;

endmodule

// File: rtl/gpio_seq.sv
// GPIO pattern sequencer: plays a table of 16-bit words onto the GPIO port.
// Define GPIO_SEQ_VERIFY_EN to read back each word and flag mismatches on err.
module gpio_seq
  import gpio_seq_pkg::*;
#(
  parameter int AW = 4,
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  input  logic [AW:0]   length,
  input  logic [IW-1:0] interval,
  input  logic [15:0]   dir_mask,
  output logic [AW-1:0] pat_addr,
  input  logic [15:0]   pat_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  gpio_seq_if.slave     cpu,
  gpio_seq_if.master    gpio
);

  seq_state_e    state_q;
  logic [AW-1:0] idx_q;
  logic [IW-1:0] cnt_q;
  logic [AW:0]   len_q;
  logic [IW-1:0] ivl_q;
  logic [15:0]   dir_q;
  logic          busy_q;
  logic          done_q;
  logic          stop_pend_q;

  logic          stall;
  logic          last_step;
  logic          quit;
  seq_state_e    after_wr;
  logic [1:0]    seq_ad;
  logic [7:0]    seq_di;
  logic          seq_rw;
  logic          seq_cs;

  gpio_port_arb u_arb (
    .cpu      (cpu),
    .gpio     (gpio),
    .seq_ad_i (seq_ad),
    .seq_di_i (seq_di),
    .seq_rw_i (seq_rw),
    .seq_cs_i (seq_cs),
    .stall_o  (stall)
  );

  assign last_step = ({1'b0, idx_q} == (len_q - (AW+1)'(1)));
  assign after_wr  = (ivl_q != '0) ? WAIT : STEP;
  assign pat_addr  = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

  always_comb begin
    seq_cs = 1'b0;
    seq_rw = 1'b1;
    seq_ad = GPIO_OUT_HI;
    seq_di = 8'h00;
    case (state_q)
      DIR_HI: begin seq_cs = 1'b1; seq_rw = 1'b0; seq_ad = GPIO_DIR_HI; seq_di = dir_q[15:8]; end
      DIR_LO: begin seq_cs = 1'b1; seq_rw = 1'b0; seq_ad = GPIO_DIR_LO; seq_di = dir_q[7:0]; end
      WR_HI:  begin seq_cs = 1'b1; seq_rw = 1'b0; seq_ad = GPIO_OUT_HI; seq_di = pat_data[15:8]; end
      WR_LO:  begin seq_cs = 1'b1; seq_rw = 1'b0; seq_ad = GPIO_OUT_LO; seq_di = pat_data[7:0]; end
`ifdef GPIO_SEQ_VERIFY_EN
      RD_HI:  begin seq_cs = 1'b1; seq_ad = GPIO_OUT_HI; end
      RD_LO:  begin seq_cs = 1'b1; seq_ad = GPIO_OUT_LO; end
`endif
      default: ;
    endcase
  end

  // A stop seen in WR_HI is deferred until the low byte has actually been
  // written, so the pins never hold a half-updated word.
  always_comb begin
    quit = 1'b0;
    case (state_q)
      IDLE:    quit = 1'b0;
      WR_HI:   quit = 1'b0;
      WR_LO:   quit = !stall && (stop || stop_pend_q);
      STEP:    quit = stop || (last_step && !loop);
      default: quit = stop;
    endcase
  end

`ifdef GPIO_SEQ_VERIFY_EN
  logic        err_q;
  logic [15:0] exp_word;
  assign exp_word = pat_data & dir_q;
  assign err      = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      ivl_q       <= '0;
      dir_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stop_pend_q <= 1'b0;
`ifdef GPIO_SEQ_VERIFY_EN
      err_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (quit) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (start && !stop) begin
              len_q       <= length;
              ivl_q       <= interval;
              dir_q       <= dir_mask;
              idx_q       <= '0;
              cnt_q       <= '0;
              stop_pend_q <= 1'b0;
`ifdef GPIO_SEQ_VERIFY_EN
              err_q       <= 1'b0;
`endif
              if (length != '0) begin
                state_q <= DIR_HI;
                busy_q  <= 1'b1;
              end else begin
                done_q  <= 1'b1;
              end
            end
          end
          DIR_HI: if (!stall) state_q <= DIR_LO;
          DIR_LO: if (!stall) state_q <= WR_HI;
          WR_HI: begin
            if (stop) stop_pend_q <= 1'b1;
            if (!stall) state_q <= WR_LO;
          end
          WR_LO: begin
            if (stop) stop_pend_q <= 1'b1;
            if (!stall) begin
              cnt_q <= '0;
`ifdef GPIO_SEQ_VERIFY_EN
              state_q <= RD_HI;
`else
              state_q <= after_wr;
`endif
            end
          end
`ifdef GPIO_SEQ_VERIFY_EN
          RD_HI: if (!stall) begin
            if (gpio.dout != exp_word[15:8]) err_q <= 1'b1;
            state_q <= RD_LO;
          end
          RD_LO: if (!stall) begin
            if (gpio.dout != exp_word[7:0]) err_q <= 1'b1;
            state_q <= after_wr;
          end
`endif
          WAIT: begin
            if (cnt_q == ivl_q - IW'(1)) state_q <= STEP;
            else cnt_q <= cnt_q + IW'(1);
          end
          STEP: begin
            idx_q   <= last_step ? '0 : idx_q + AW'(1);
            state_q <= WR_HI;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gpio_seq.sv
// Self-checking bench for gpio_seq: GPIO peripheral model, write/done monitor
// and a timing model computed from step period arithmetic.
module tb_gpio_seq;
  localparam int AW = 4;
  localparam int IW = 16;
`ifdef GPIO_SEQ_VERIFY_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, stop, loop;
  logic [AW:0]   length;
  logic [IW-1:0] interval;
  logic [15:0]   dir_mask;
  logic [AW-1:0] pat_addr;
  logic [15:0]   pat_data;
  logic          busy, done, err;

  gpio_seq_if cpu_bus ();
  gpio_seq_if gpio_bus ();

  gpio_seq #(.AW(AW), .IW(IW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .loop     (loop),
    .length   (length),
    .interval (interval),
    .dir_mask (dir_mask),
    .pat_addr (pat_addr),
    .pat_data (pat_data),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cpu      (cpu_bus),
    .gpio     (gpio_bus)
  );

  always #5 clk = ~clk;

  logic [15:0] tbl [2**AW];
  assign pat_data = tbl[pat_addr];

  // GPIO peripheral: registers are never reset by the sequencer's rst
  logic [15:0] g_out_q = '0;
  logic [15:0] g_dir_q = '0;
  logic [15:0] pin_low = '0;
  logic [15:0] pins;
  assign pins = g_out_q & g_dir_q & ~pin_low;

  always_comb begin
    case (gpio_bus.ad)
      2'b00:   gpio_bus.dout = pins[15:8];
      2'b01:   gpio_bus.dout = pins[7:0];
      2'b10:   gpio_bus.dout = g_dir_q[15:8];
      default: gpio_bus.dout = g_dir_q[7:0];
    endcase
  end

  always @(posedge clk) begin
    if (gpio_bus.cs && !gpio_bus.rw) begin
      case (gpio_bus.ad)
        2'b00:   g_out_q[15:8] <= gpio_bus.di;
        2'b01:   g_out_q[7:0]  <= gpio_bus.di;
        2'b10:   g_dir_q[15:8] <= gpio_bus.di;
        default: g_dir_q[7:0]  <= gpio_bus.di;
      endcase
    end
  end

  int          cyc = 0;
  int          gcs_cnt = 0;
  int          wr_cyc_q[$];
  logic [15:0] wr_word_q[$];
  int          done_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (gpio_bus.cs) gcs_cnt <= gcs_cnt + 1;
    if (gpio_bus.cs && !gpio_bus.rw && gpio_bus.ad == 2'b01) begin
      wr_cyc_q.push_back(cyc);
      wr_word_q.push_back({g_out_q[15:8], gpio_bus.di});
    end
    if (done) done_cyc_q.push_back(cyc);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    wr_cyc_q.delete();
    wr_word_q.delete();
    done_cyc_q.delete();
  endtask

  task automatic pulse_start(input int len, input int ivl, input logic [15:0] dm,
                             input logic lp, output int s);
    length   = (AW+1)'(len);
    interval = IW'(ivl);
    dir_mask = dm;
    loop     = lp;
    start    = 1'b1;
    s        = cyc;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, " idle"}, 32'(n < budget), 32'd1);
    tick(2);
  endtask

  // write k lands at s+4+k*p (+d once k>=dk); word k is table entry k mod len
  task automatic check_play(input string tag, input int s, input int len, input int nwr,
                            input int p, input int dk, input int d, input int done_exp,
                            input logic [15:0] dm);
    check({tag, " writes"}, 32'(wr_cyc_q.size()), 32'(nwr));
    for (int k = 0; k < nwr && k < wr_cyc_q.size(); k++) begin
      check($sformatf("%s word%0d", tag, k), {16'h0, wr_word_q[k]}, {16'h0, tbl[k % len]});
      check($sformatf("%s time%0d", tag, k), 32'(wr_cyc_q[k]),
            32'(s + 4 + k * p + ((k >= dk) ? d : 0)));
    end
    check({tag, " done count"}, 32'(done_cyc_q.size()), 32'd1);
    if (done_cyc_q.size() > 0) check({tag, " done time"}, 32'(done_cyc_q[0]), 32'(done_exp));
    check({tag, " pins"}, {16'h0, pins}, {16'h0, tbl[(nwr - 1) % len] & dm});
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int s, n, ivl, p, g0;
    logic [15:0] dm;

    rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
    length = '0; interval = '0; dir_mask = '0;
    cpu_bus.ad = 2'b00; cpu_bus.di = 8'h00; cpu_bus.rw = 1'b1; cpu_bus.cs = 1'b0;
    for (int i = 0; i < 2**AW; i++) tbl[i] = 16'h0000;
    tick(3);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst pat_addr", 32'(pat_addr), 32'd0);
    check("rst g_cs", 32'(gpio_bus.cs), 32'd0);
    check("rst g_rw", 32'(gpio_bus.rw), 32'd1);
    check("rst err", 32'(err), 32'd0);
    rst = 1'b0;
    tick(1);

    // basic playback
    tbl[0] = 16'hA5F0; tbl[1] = 16'h0F0F; tbl[2] = 16'hFFFF;
    clear_mon();
    pulse_start(3, 2, 16'hFFFF, 1'b0, s);
    check("basic busy", 32'(busy), 32'd1);
    wait_idle("basic", 200);
    p = 5 + EXTRA;
    check_play("basic", s, 3, 3, p, 99, 0, s + 3 * p + 3, 16'hFFFF);
    $display("basic: 3 steps, period %0d", p);

    // randomized single-shot runs
    for (int t = 0; t < 6; t++) begin
      n   = $urandom_range(16, 1);
      ivl = $urandom_range(4, 0);
      dm  = 16'($urandom);
      for (int i = 0; i < 2**AW; i++) tbl[i] = 16'($urandom);
      clear_mon();
      pulse_start(n, ivl, dm, 1'b0, s);
      wait_idle($sformatf("rand%0d", t), 1000);
      p = ivl + 3 + EXTRA;
      check_play($sformatf("rand%0d", t), s, n, n, p, 99, 0, s + n * p + 3, dm);
      $display("rand%0d: length=%0d interval=%0d dir=%h", t, n, ivl, dm);
    end

    // zero length start
    clear_mon();
    g0 = gcs_cnt;
    pulse_start(0, 3, 16'hFFFF, 1'b0, s);
    check("len0 done", 32'(done), 32'd1);
    check("len0 busy", 32'(busy), 32'd0);
    tick(1);
    check("len0 done clr", 32'(done), 32'd0);
    tick(3);
    check("len0 no bus", 32'(gcs_cnt), 32'(g0));
    check("len0 done count", 32'(done_cyc_q.size()), 32'd1);
    $display("len0: done pulse seen");

    // start and stop together: stop wins
    clear_mon();
    length = 5'd3; interval = '0; start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    check("start+stop busy", 32'(busy), 32'd0);
    tick(2);
    check("start+stop done", 32'(done_cyc_q.size()), 32'd0);
    $display("start+stop: ignored");

    // start while busy is ignored
    for (int i = 0; i < 2**AW; i++) tbl[i] = 16'($urandom);
    clear_mon();
    pulse_start(2, 3, 16'hFF00, 1'b0, s);
    tick(4);
    length = 5'd9; interval = '0; dir_mask = 16'h1234; start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_idle("busy-start", 200);
    p = 6 + EXTRA;
    check_play("busy-start", s, 2, 2, p, 99, 0, s + 2 * p + 3, 16'hFF00);
    $display("busy-start: second start ignored");

    // loop with stop during WR_HI of step 4
    tbl[0] = 16'h1111; tbl[1] = 16'h2222;
    clear_mon();
    pulse_start(2, 0, 16'hFFFF, 1'b1, s);
    p = 3 + EXTRA;
    while (cyc < s + 3 + 4 * p) tick(1);
    check("loop stop at WR_HI", {29'h0, gpio_bus.ad, gpio_bus.cs, gpio_bus.rw}, 32'b0010);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("loop stop WR_LO", {29'h0, gpio_bus.ad, gpio_bus.cs, gpio_bus.rw}, 32'b0110);
    wait_idle("loop-stop", 50);
    loop = 1'b0;
    check_play("loop-stop", s, 2, 5, p, 99, 0, s + 3 + 4 * p + 2, 16'hFFFF);
    $display("loop-stop: 5 words then stop");

    // CPU contention for 4 cycles during WR_HI of step 1
    for (int i = 0; i < 2**AW; i++) tbl[i] = 16'($urandom);
    dm = 16'($urandom);
    clear_mon();
    pulse_start(3, 1, dm, 1'b0, s);
    p = 4 + EXTRA;
    while (cyc < s + 3 + p) tick(1);
    #2;
    check("cont seq WR_HI", {30'h0, gpio_bus.ad}, 32'd0);
    cpu_bus.ad = 2'b11; cpu_bus.rw = 1'b1; cpu_bus.cs = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("cont c_do%0d", i), {24'h0, cpu_bus.dout}, {24'h0, dm[7:0]});
      check($sformatf("cont g_ad%0d", i), {30'h0, gpio_bus.ad}, 32'd3);
      @(negedge clk);
      #2;
    end
    cpu_bus.cs = 1'b0;
    #1;
    check("cont resume", {29'h0, gpio_bus.ad, gpio_bus.cs, gpio_bus.rw}, 32'b0010);
    wait_idle("contention", 200);
    check_play("contention", s, 3, 3, p, 1, 4, s + 3 * p + 3 + 4, dm);
    $display("contention: step 1 delayed by 4");

    // reset during WAIT
    for (int i = 0; i < 2**AW; i++) tbl[i] = 16'($urandom);
    clear_mon();
    pulse_start(2, 5, 16'hFFFF, 1'b0, s);
    while (cyc < s + 6 + EXTRA) tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rstwait busy", 32'(busy), 32'd0);
    check("rstwait g_cs", 32'(gpio_bus.cs), 32'd0);
    check("rstwait pat_addr", 32'(pat_addr), 32'd0);
    tick(10);
    check("rstwait writes", 32'(wr_cyc_q.size()), 32'd1);
    check("rstwait no done", 32'(done_cyc_q.size()), 32'd0);
    check("rstwait pins", {16'h0, pins}, {16'h0, tbl[0]});
    $display("reset-in-wait: pins hold %h", tbl[0]);

`ifdef GPIO_SEQ_VERIFY_EN
    // read-back verification
    tbl[0] = 16'h1234;
    clear_mon();
    pulse_start(1, 0, 16'h00FF, 1'b0, s);
    wait_idle("vfy ok", 100);
    check("vfy readback", {16'h0, pins}, 32'h0034);
    check("vfy ok err", 32'(err), 32'd0);
    pin_low = 16'h0004;
    pulse_start(1, 0, 16'h00FF, 1'b0, s);
    wait_idle("vfy bad", 100);
    check("vfy bad err", 32'(err), 32'd1);
    pin_low = 16'h0000;
    tick(5);
    check("vfy sticky", 32'(err), 32'd1);
    pulse_start(1, 0, 16'h00FF, 1'b0, s);
    check("vfy clr on start", 32'(err), 32'd0);
    wait_idle("vfy clr", 100);
    check("vfy clr err", 32'(err), 32'd0);
    $display("verify: mismatch flagged and cleared");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
